tilelink_acquire_arbiter: RTL and testbench
===========================================

Name: tilelink_acquire_arbiter

Overview:
- Shares one manager-side TileLink Acquire channel between N_CLIENTS client-side Acquire channels using round-robin arbitration.
- Locks the grant onto one client for the full duration of a multi-beat uncached write.
- Extends each client_xact_id with the client index on the way out.
- Steers returning Grant beats back to the owning client by that index.
- Sits between the L1/IO clients and the uncached TileLink manager (memory/IO bridge).

Parameters:
- N_CLIENTS, 4, number of requesting clients (2..8).
- IDX_W, $clog2(N_CLIENTS), client index width.
- ADDR_W, `TLAddrBits, acquire address width.
- CXID_W, `TLClientXactIdBits, client transaction id width.
- MXID_W, `TLMasterXactIdBits, manager transaction id width.
- DATA_W, `TLDataBits, data beat width.
- BEATS, 4, data beats per uncached write burst (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- c_acq_valid  in  N_CLIENTS  per-client acquire valid
- c_acq_ready  out  N_CLIENTS  per-client acquire ready
- c_acq_addr  in  N_CLIENTS*ADDR_W  packed client addresses
- c_acq_cxid  in  N_CLIENTS*CXID_W  packed client xact ids
- c_acq_data  in  N_CLIENTS*DATA_W  packed data beats
- c_acq_uncached  in  N_CLIENTS  uncached flags
- c_acq_type  in  N_CLIENTS*`acquireTypeWidth  packed a_type
- c_acq_subblock  in  N_CLIENTS*`TLSubblockBits  packed subblock
- m_acq_valid  out  1  manager acquire valid
- m_acq_ready  in  1  manager acquire ready
- m_acq_addr / m_acq_data / m_acq_uncached / m_acq_type / m_acq_subblock  out  per field  selected client's fields
- m_acq_cxid  out  CXID_W+IDX_W  {grant_idx, client cxid}
- m_gnt_valid  in  1  manager grant valid
- m_gnt_ready  out  1  manager grant ready
- m_gnt_cxid  in  CXID_W+IDX_W  extended client xact id
- m_gnt_mxid / m_gnt_data / m_gnt_type  in  per field  grant payload
- c_gnt_valid  out  N_CLIENTS  per-client grant valid
- c_gnt_ready  in  N_CLIENTS  per-client grant ready
- c_gnt_cxid  out  CXID_W  m_gnt_cxid[CXID_W-1:0], broadcast
- c_gnt_mxid / c_gnt_data / c_gnt_type  out  per field  broadcast grant payload

Behaviour:
- State: rr_ptr (IDX_W), lock (1), lock_idx (IDX_W), beat_cnt ($clog2(BEATS)).
- Reset: rr_ptr=0, lock=0, beat_cnt=0. While reset=1: m_acq_valid=0, c_acq_ready=0, c_gnt_valid=0, m_gnt_ready=0.
- Unlocked selection, combinational same-cycle (zero latency, no buffering): the first valid client scanning rr_ptr, rr_ptr+1, … modulo N_CLIENTS. m_acq_valid = any valid. m_acq_* = selected client's fields. c_acq_ready[sel] = m_acq_ready; all other ready bits are 0.
- Locked: selection is forced to lock_idx. Other clients' valid is ignored.
- Handshake = m_acq_valid & m_acq_ready.
  - Unlocked handshake with a_type==`acquireUncachedWrite: lock←1, lock_idx←sel, beat_cnt←1.
  - Unlocked handshake with any other type (read, atomic): single beat, no lock. rr_ptr←sel+1 mod N.
  - Locked handshake: beat_cnt←beat_cnt+1. On the beat where beat_cnt==BEATS-1: lock←0, beat_cnt←0, rr_ptr←lock_idx+1 mod N.
- Locked client dropping valid mid-burst: lock holds and m_acq_valid=0; no other client is granted.
- Fields must be stable while valid & !ready (clients' obligation). Arbiter choice must not change while m_acq_valid & !m_acq_ready:
  - Unlocked stall: hold the current selection in a registered hold_idx until the handshake completes.
- Grant path, combinational: idx=m_gnt_cxid[CXID_W+IDX_W-1:CXID_W]. c_gnt_valid[idx]=m_gnt_valid, others 0. m_gnt_ready=c_gnt_ready[idx]. An idx ≥ N_CLIENTS drops the beat (m_gnt_ready=1, no client valid).
- Acquire and grant paths are independent. Simultaneous handshakes on both are legal.
- Reset mid-burst: lock cleared; the burst is abandoned.

Optional Feature:
- Macro: TL_ACQ_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, client 0 highest. rr_ptr is not implemented and selection always scans from 0. Write burst locking is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset, then clients 0 and 2 assert read acquires with m_acq_ready=1 -> client 0 granted cycle 1, client 2 cycle 2; m_acq_cxid={0,cxid0}, then {2,cxid2}.
- Client 1 issues an uncached write burst of 4 beats while client 3 holds a read -> 4 consecutive client-1 beats; client 3 granted on cycle 5; rr_ptr=2 after the burst.
- Client 1 writes and drops valid after beat 2 for 3 cycles while client 0 is valid -> m_acq_valid=0 for 3 cycles, client 0 is not granted, burst resumes at beat 3.
- m_acq_ready=0 for 5 cycles with clients 0 and 1 valid -> m_acq_* stable on client 0 throughout; client 1 accepted next.
- Grant with m_gnt_cxid={3,0x5}, c_gnt_ready[3]=0 for 2 cycles -> c_gnt_valid=4'b1000, m_gnt_ready=0 for 2 cycles then 1, c_gnt_cxid=0x5.
- Fixed-priority build, all 4 clients issuing continuous reads -> client 0 granted every cycle, clients 1-3 never granted.

Source files
------------

// File: rtl/tilelink_acquire_arbiter.sv
// tilelink_acquire_arbiter: shares one TileLink Acquire channel among N clients, locks on uncached write bursts, steers Grants back by index.
// Define TL_ACQ_ARB_FIXED_PRIO_EN for fixed priority (client 0 highest) instead of round-robin.
`ifndef TLAddrBits
`define TLAddrBits 32
`endif
`ifndef TLClientXactIdBits
`define TLClientXactIdBits 4
`endif
`ifndef TLMasterXactIdBits
`define TLMasterXactIdBits 4
`endif
`ifndef TLDataBits
`define TLDataBits 32
`endif
`ifndef acquireTypeWidth
`define acquireTypeWidth 3
`endif
`ifndef TLSubblockBits
`define TLSubblockBits 8
`endif
`ifndef grantTypeWidth
`define grantTypeWidth 4
`endif
`ifndef acquireUncachedWrite
`define acquireUncachedWrite 3'd2
`endif

module tilelink_acquire_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int IDX_W = $clog2(N_CLIENTS),
  parameter int ADDR_W = `TLAddrBits,
  parameter int CXID_W = `TLClientXactIdBits,
  parameter int MXID_W = `TLMasterXactIdBits,
  parameter int DATA_W = `TLDataBits,
  parameter int BEATS = 4,
  parameter int TYPE_W = `acquireTypeWidth,
  parameter int SUB_W = `TLSubblockBits,
  parameter int GTYPE_W = `grantTypeWidth
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CLIENTS-1:0]        c_acq_valid,
  output logic [N_CLIENTS-1:0]        c_acq_ready,
  input  logic [N_CLIENTS*ADDR_W-1:0] c_acq_addr,
  input  logic [N_CLIENTS*CXID_W-1:0] c_acq_cxid,
  input  logic [N_CLIENTS*DATA_W-1:0] c_acq_data,
  input  logic [N_CLIENTS-1:0]        c_acq_uncached,
  input  logic [N_CLIENTS*TYPE_W-1:0] c_acq_type,
  input  logic [N_CLIENTS*SUB_W-1:0]  c_acq_subblock,
  output logic                        m_acq_valid,
  input  logic                        m_acq_ready,
  output logic [ADDR_W-1:0]           m_acq_addr,
  output logic [DATA_W-1:0]           m_acq_data,
  output logic                        m_acq_uncached,
  output logic [TYPE_W-1:0]           m_acq_type,
  output logic [SUB_W-1:0]            m_acq_subblock,
  output logic [CXID_W+IDX_W-1:0]     m_acq_cxid,
  input  logic                        m_gnt_valid,
  output logic                        m_gnt_ready,
  input  logic [CXID_W+IDX_W-1:0]     m_gnt_cxid,
  input  logic [MXID_W-1:0]           m_gnt_mxid,
  input  logic [DATA_W-1:0]           m_gnt_data,
  input  logic [GTYPE_W-1:0]          m_gnt_type,
  output logic [N_CLIENTS-1:0]        c_gnt_valid,
  input  logic [N_CLIENTS-1:0]        c_gnt_ready,
  output logic [CXID_W-1:0]           c_gnt_cxid,
  output logic [MXID_W-1:0]           c_gnt_mxid,
  output logic [DATA_W-1:0]           c_gnt_data,
  output logic [GTYPE_W-1:0]          c_gnt_type
);
  localparam int CNT_W = $clog2(BEATS);
  logic lock_q, lock_d, hold_q, hold_d, found, hs, is_write, last_beat;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d, hold_idx_q, hold_idx_d, scan_idx, sel, rr_base, gidx;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [N_CLIENTS-1:0] g_oh;
  always_comb begin
    found = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < N_CLIENTS; i++)
      if (!found && c_acq_valid[IDX_W'((int'(rr_base) + i) % N_CLIENTS)]) begin
        found = 1'b1;
        scan_idx = IDX_W'((int'(rr_base) + i) % N_CLIENTS);
      end
  end
  // A burst owner or a stalled winner keeps the channel; otherwise take the scan result.
  assign sel = lock_q ? lock_idx_q : hold_q ? hold_idx_q : scan_idx;
  assign m_acq_valid = !reset && c_acq_valid[sel];
  assign c_acq_ready = (m_acq_ready && !reset) ? N_CLIENTS'(1) << sel : '0;
  assign m_acq_addr = c_acq_addr[int'(sel)*ADDR_W +: ADDR_W];
  assign m_acq_data = c_acq_data[int'(sel)*DATA_W +: DATA_W];
  assign m_acq_uncached = c_acq_uncached[sel];
  assign m_acq_type = c_acq_type[int'(sel)*TYPE_W +: TYPE_W];
  assign m_acq_subblock = c_acq_subblock[int'(sel)*SUB_W +: SUB_W];
  assign m_acq_cxid = {sel, c_acq_cxid[int'(sel)*CXID_W +: CXID_W]};
  assign hs = m_acq_valid && m_acq_ready;
  assign is_write = m_acq_type == TYPE_W'(`acquireUncachedWrite);
  assign last_beat = beat_q == CNT_W'(BEATS - 1);
  always_comb begin
    lock_d = lock_q;
    lock_idx_d = lock_idx_q;
    beat_d = beat_q;
    hold_d = m_acq_valid && !m_acq_ready && !lock_q;
    hold_idx_d = sel;
    if (hs && lock_q) begin
      beat_d = last_beat ? '0 : beat_q + CNT_W'(1);
      lock_d = !last_beat;
    end else if (hs && is_write) begin
      lock_d = 1'b1;
      lock_idx_d = sel;
      beat_d = CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
      lock_idx_q <= '0;
      beat_q <= '0;
      hold_q <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      lock_q <= lock_d;
      lock_idx_q <= lock_idx_d;
      beat_q <= beat_d;
      hold_q <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end
`ifdef TL_ACQ_ARB_FIXED_PRIO_EN
  assign rr_base = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign rr_base = rr_ptr_q;
  // Pointer advances past a single-beat winner, or past the burst owner on its last beat.
  assign rr_ptr_d = (hs && (lock_q ? last_beat : !is_write)) ? IDX_W'((int'(sel) + 1) % N_CLIENTS) : rr_ptr_q;
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end
`endif
  // An out-of-range index yields an empty one-hot, so the beat is sunk.
  assign gidx = m_gnt_cxid[CXID_W+IDX_W-1:CXID_W];
  assign g_oh = N_CLIENTS'(1) << gidx;
  assign c_gnt_valid = (m_gnt_valid && !reset) ? g_oh : '0;
  assign m_gnt_ready = !reset && ((|g_oh) ? |(c_gnt_ready & g_oh) : 1'b1);
  assign c_gnt_cxid = m_gnt_cxid[CXID_W-1:0];
  assign c_gnt_mxid = m_gnt_mxid;
  assign c_gnt_data = m_gnt_data;
  assign c_gnt_type = m_gnt_type;
endmodule

// File: tb/tb_tilelink_acquire_arbiter.sv
// tb_tilelink_acquire_arbiter: directed checks of arbitration, burst lock, stall hold and grant steering.
`ifndef acquireUncachedWrite
`define acquireUncachedWrite 3'd2
`endif

module tb_tilelink_acquire_arbiter;
  localparam int N = 4, AW = 32, CW = 4, MW = 4, DW = 32, TW = 3, SW = 8, GW = 4;
  localparam logic [TW-1:0] WR = `acquireUncachedWrite;
  localparam logic [TW-1:0] RD = 3'd0;
  logic clk, reset, m_acq_valid, m_acq_ready, m_acq_uncached, m_gnt_valid, m_gnt_ready;
  logic [N-1:0] c_acq_valid, c_acq_ready, c_acq_uncached, c_gnt_valid, c_gnt_ready;
  logic [N*AW-1:0] c_acq_addr;
  logic [N*CW-1:0] c_acq_cxid;
  logic [N*DW-1:0] c_acq_data;
  logic [N*TW-1:0] c_acq_type;
  logic [N*SW-1:0] c_acq_subblock;
  logic [AW-1:0] m_acq_addr;
  logic [DW-1:0] m_acq_data, m_gnt_data, c_gnt_data;
  logic [TW-1:0] m_acq_type;
  logic [SW-1:0] m_acq_subblock;
  logic [CW+1:0] m_acq_cxid, m_gnt_cxid;
  logic [MW-1:0] m_gnt_mxid, c_gnt_mxid;
  logic [GW-1:0] m_gnt_type, c_gnt_type;
  logic [CW-1:0] c_gnt_cxid;
  int checks = 0, errors = 0;

  tilelink_acquire_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .CXID_W(CW), .MXID_W(MW), .DATA_W(DW),
    .BEATS(4), .TYPE_W(TW), .SUB_W(SW), .GTYPE_W(GW)) dut (
    .clk(clk), .reset(reset), .c_acq_valid(c_acq_valid), .c_acq_ready(c_acq_ready),
    .c_acq_addr(c_acq_addr), .c_acq_cxid(c_acq_cxid), .c_acq_data(c_acq_data),
    .c_acq_uncached(c_acq_uncached), .c_acq_type(c_acq_type), .c_acq_subblock(c_acq_subblock),
    .m_acq_valid(m_acq_valid), .m_acq_ready(m_acq_ready), .m_acq_addr(m_acq_addr),
    .m_acq_data(m_acq_data), .m_acq_uncached(m_acq_uncached), .m_acq_type(m_acq_type),
    .m_acq_subblock(m_acq_subblock), .m_acq_cxid(m_acq_cxid), .m_gnt_valid(m_gnt_valid),
    .m_gnt_ready(m_gnt_ready), .m_gnt_cxid(m_gnt_cxid), .m_gnt_mxid(m_gnt_mxid),
    .m_gnt_data(m_gnt_data), .m_gnt_type(m_gnt_type), .c_gnt_valid(c_gnt_valid),
    .c_gnt_ready(c_gnt_ready), .c_gnt_cxid(c_gnt_cxid), .c_gnt_mxid(c_gnt_mxid),
    .c_gnt_data(c_gnt_data), .c_gnt_type(c_gnt_type));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic acq(input string tag, input logic v, input logic [N-1:0] rdy, input logic [CW+1:0] cx);
    chk({tag, ".valid"}, 64'(m_acq_valid), 64'(v));
    chk({tag, ".ready"}, 64'(c_acq_ready), 64'(rdy));
    if (v) chk({tag, ".cxid"}, 64'(m_acq_cxid), 64'(cx));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clk = 0;
    reset = 1;
    c_acq_valid = '1;
    m_acq_ready = 1;
    c_acq_uncached = '1;
    c_acq_type = '0;
    m_gnt_valid = 1;
    m_gnt_cxid = 6'h35;
    m_gnt_mxid = 4'h9;
    m_gnt_data = 32'hCAFE0001;
    m_gnt_type = 4'h3;
    c_gnt_ready = '1;
    for (int i = 0; i < N; i++) begin
      c_acq_addr[i*AW +: AW] = 32'(32'h1000 + i);
      c_acq_cxid[i*CW +: CW] = 4'(4'hA + i);
      c_acq_data[i*DW +: DW] = 32'(32'hD0000000 + i);
      c_acq_subblock[i*SW +: SW] = 8'(8'h50 + i);
    end
    repeat (2) begin
      tick();
      chk("rst.m_acq_valid", 64'(m_acq_valid), 64'(0));
      chk("rst.c_acq_ready", 64'(c_acq_ready), 64'(0));
      chk("rst.c_gnt_valid", 64'(c_gnt_valid), 64'(0));
      chk("rst.m_gnt_ready", 64'(m_gnt_ready), 64'(0));
    end
    reset = 0;
    c_acq_valid = '0;
    m_gnt_valid = 0;
    tick();
    c_acq_valid = 4'b0101;
    #1 acq("t1.c0", 1, 4'b0001, 6'h0A);
    chk("t1.addr", 64'(m_acq_addr), 64'h1000);
    chk("t1.sub", 64'(m_acq_subblock), 64'h50);
    tick();
    #1 acq("t1.c2", 1, 4'b0100, 6'h2C);
    chk("t1.data", 64'(m_acq_data), 64'hD0000002);
    tick();
    #1 acq("t1.wrap", 1, 4'b0001, 6'h0A);
    tick();
    c_acq_type[TW +: TW] = WR;
    c_acq_valid = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      c_acq_data[DW +: DW] = 32'(32'hB0 + k);
      #1 acq("t2.beat", 1, 4'b0010, 6'h1B);
      chk("t2.data", 64'(m_acq_data), 64'(32'hB0 + k));
      chk("t2.type", 64'(m_acq_type), 64'(WR));
      tick();
    end
    c_acq_valid = 4'b1001;
    #1 acq("t2.after", 1, 4'b1000, 6'h3D);
    tick();
    c_acq_valid = 4'b0010;
    c_acq_data[DW +: DW] = 32'hB0;
    #1 acq("t3.b0", 1, 4'b0010, 6'h1B);
    tick();
    c_acq_valid = 4'b0011;
    c_acq_data[DW +: DW] = 32'hB1;
    #1 acq("t3.b1", 1, 4'b0010, 6'h1B);
    tick();
    c_acq_valid = 4'b0001;
    repeat (3) begin
      #1 acq("t3.gap", 0, 4'b0010, 6'h00);
      tick();
    end
    c_acq_valid = 4'b0011;
    for (int k = 2; k < 4; k++) begin
      c_acq_data[DW +: DW] = 32'(32'hB0 + k);
      #1 acq("t3.resume", 1, 4'b0010, 6'h1B);
      chk("t3.data", 64'(m_acq_data), 64'(32'hB0 + k));
      tick();
    end
    c_acq_type[TW +: TW] = RD;
    m_acq_ready = 0;
    #1 acq("t4.stall0", 1, 4'b0000, 6'h0A);
    tick();
    c_acq_valid = 4'b1011;
    repeat (4) begin
      #1 acq("t4.stall", 1, 4'b0000, 6'h0A);
      chk("t4.addr", 64'(m_acq_addr), 64'h1000);
      tick();
    end
    m_acq_ready = 1;
    #1 acq("t4.go", 1, 4'b0001, 6'h0A);
    tick();
    c_acq_valid = 4'b1010;
    #1 acq("t4.next", 1, 4'b0010, 6'h1B);
    tick();
    c_acq_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ix;
`ifdef TL_ACQ_ARB_FIXED_PRIO_EN
      ix = 2'd0;
`else
      ix = 2'(2 + k);
`endif
      #1 acq("t5.order", 1, 4'(4'b0001 << ix), {ix, 4'(4'hA + ix)});
      tick();
    end
    c_acq_type[TW +: TW] = WR;
    c_acq_valid = 4'b0010;
    #1 acq("t6.burst", 1, 4'b0010, 6'h1B);
    tick();
    reset = 1;
    tick();
    reset = 0;
    c_acq_valid = 4'b0011;
    #1 acq("t6.unlocked", 1, 4'b0001, 6'h0A);
    tick();
    c_acq_valid = '0;
    c_acq_type[TW +: TW] = RD;
    m_gnt_valid = 1;
    m_gnt_cxid = 6'h35;
    c_gnt_ready = 4'b0111;
    repeat (2) begin
      #1 chk("g.valid3", 64'(c_gnt_valid), 64'b1000);
      chk("g.stall", 64'(m_gnt_ready), 64'(0));
      chk("g.cxid", 64'(c_gnt_cxid), 64'h5);
      chk("g.mxid", 64'(c_gnt_mxid), 64'h9);
      chk("g.data", 64'(c_gnt_data), 64'hCAFE0001);
      tick();
    end
    c_gnt_ready = 4'b1000;
    #1 chk("g.ready3", 64'(m_gnt_ready), 64'(1));
    chk("g.type", 64'(c_gnt_type), 64'h3);
    tick();
    m_gnt_cxid = 6'h17;
    c_gnt_ready = 4'b0010;
    #1 chk("g.valid1", 64'(c_gnt_valid), 64'b0010);
    chk("g.ready1", 64'(m_gnt_ready), 64'(1));
    chk("g.cxid1", 64'(c_gnt_cxid), 64'h7);
    c_gnt_ready = 4'b1101;
    #1 chk("g.notready1", 64'(m_gnt_ready), 64'(0));
    m_gnt_valid = 0;
    #1 chk("g.idle", 64'(c_gnt_valid), 64'(0));
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
